rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port (wr/addr3/data3) among three writeback requesters: 0 = ALU result, 1 = load data, 2 = exception/link write (e.g. PC save).
- Arbitrates round-robin with a valid/ready handshake and registers the winning write into a one-entry output stage that drives the register file.
- Provides a bypass for two read addresses so that readers see the in-flight write one cycle before the register file commits it.

---
 rtl/rf_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among ALU, load and
// exception/link writeback, with a one-entry output stage and two read bypasses.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic [2:0]    req_valid,
    output logic [2:0]    req_ready,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [AW-1:0] req_addr2,
    input  logic [DW-1:0] req_data0,
    input  logic [DW-1:0] req_data1,
    input  logic [DW-1:0] req_data2,
    output logic          rf_wr,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_data,
    output logic [1:0]    grant_id,
    input  logic [AW-1:0] byp_addr1,
    input  logic [AW-1:0] byp_addr2,
    output logic          byp_hit1,
    output logic          byp_hit2,
    output logic [DW-1:0] byp_data1,
    output logic [DW-1:0] byp_data2
);

    logic [AW-1:0] addr_arr [3];
    logic [DW-1:0] data_arr [3];

    assign addr_arr[0] = req_addr0;
    assign addr_arr[1] = req_addr1;
    assign addr_arr[2] = req_addr2;
    assign data_arr[0] = req_data0;
    assign data_arr[1] = req_data1;
    assign data_arr[2] = req_data2;

    logic          rf_wr_reg,    rf_wr_next;
    logic [AW-1:0] rf_addr_reg,  rf_addr_next;
    logic [DW-1:0] rf_data_reg,  rf_data_next;
    logic [1:0]    grant_id_reg, grant_id_next;
    logic [1:0]    last_reg,     last_next;

    logic [1:0] start_idx;
    logic [2:0] scan_idx;
    logic       grant_valid;
    logic [1:0] grant_idx;

    // Scan begins just past the last winner; wrap the 0..4 sum back into 0..2.
    always_comb begin
        start_idx   = (last_reg >= 2'd2) ? 2'd0 : last_reg + 2'd1;
        scan_idx    = 3'd0;
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        if (!hold && !reset) begin
            for (int k = 0; k < 3; k++) begin
                scan_idx = {1'b0, start_idx} + 3'(k);
                if (scan_idx >= 3'd3) begin
                    scan_idx = scan_idx - 3'd3;
                end
                if (!grant_valid && req_valid[scan_idx[1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_idx[1:0];
                end
            end
        end
        req_ready = grant_valid ? (3'b001 << grant_idx) : 3'b000;
    end

    always_comb begin
        rf_wr_next    = 1'b0;
        rf_addr_next  = rf_addr_reg;
        rf_data_next  = rf_data_reg;
        grant_id_next = grant_id_reg;
        last_next     = last_reg;
        if (grant_valid) begin
            // Writes to $0 are consumed but never reach the register file.
            rf_wr_next    = (addr_arr[grant_idx] != '0);
            rf_addr_next  = addr_arr[grant_idx];
            rf_data_next  = data_arr[grant_idx];
            grant_id_next = grant_idx;
            last_next     = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_wr_reg    <= 1'b0;
            rf_addr_reg  <= '0;
            rf_data_reg  <= '0;
            grant_id_reg <= 2'd0;
            last_reg     <= 2'd2;
        end else begin
            rf_wr_reg    <= rf_wr_next;
            rf_addr_reg  <= rf_addr_next;
            rf_data_reg  <= rf_data_next;
            grant_id_reg <= grant_id_next;
            last_reg     <= last_next;
        end
    end

    assign rf_wr    = rf_wr_reg;
    assign rf_addr  = rf_addr_reg;
    assign rf_data  = rf_data_reg;
    assign grant_id = grant_id_reg;

    logic [AW-1:0] byp_addr_arr [2];
    logic [1:0]    byp_hit_arr;
    logic [DW-1:0] byp_data_arr [2];

    assign byp_addr_arr[0] = byp_addr1;
    assign byp_addr_arr[1] = byp_addr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_byp
            assign byp_hit_arr[gi]  = rf_wr_reg && (byp_addr_arr[gi] == rf_addr_reg)
                                      && (byp_addr_arr[gi] != '0);
            assign byp_data_arr[gi] = byp_hit_arr[gi] ? rf_data_reg : '0;
        end
    endgenerate

    assign byp_hit1  = byp_hit_arr[0];
    assign byp_hit2  = byp_hit_arr[1];
    assign byp_data1 = byp_data_arr[0];
    assign byp_data2 = byp_data_arr[1];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by constrained-random traffic,
// all checked against a cycle-level reference model of the writeback port.
module tb_rf_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          hold;
    logic [2:0]    req_valid;
    logic [2:0]    req_ready;
    logic [AW-1:0] ta [3];
    logic [DW-1:0] td [3];
    logic          rf_wr;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic [1:0]    grant_id;
    logic [AW-1:0] byp_addr1, byp_addr2;
    logic          byp_hit1, byp_hit2;
    logic [DW-1:0] byp_data1, byp_data2;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: the pending register-file write and the last winner.
    int            m_last;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_gid;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr0(ta[0]), .req_addr1(ta[1]), .req_addr2(ta[2]),
        .req_data0(td[0]), .req_data1(td[1]), .req_data2(td[2]),
        .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data), .grant_id(grant_id),
        .byp_addr1(byp_addr1), .byp_addr2(byp_addr2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner = first valid requester counting upward from the one after the last winner.
    function automatic int model_winner();
        if (hold || reset) return -1;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_last + 1 + k) % 3;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [2:0] model_ready();
        int w;
        w = model_winner();
        return (w < 0) ? 3'b000 : 3'(1 << w);
    endfunction

    function automatic logic model_hit(input logic [AW-1:0] a);
        return m_wr && (a == m_addr) && (a != 0);
    endfunction

    task automatic settle();
        @(negedge clk);
        chk("ready",    {61'd0, req_ready}, {61'd0, model_ready()});
        chk("rf_wr",    {63'd0, rf_wr},     {63'd0, m_wr});
        chk("rf_addr",  {59'd0, rf_addr},   {59'd0, m_addr});
        chk("rf_data",  {32'd0, rf_data},   {32'd0, m_data});
        chk("grant_id", {62'd0, grant_id},  64'(m_gid));
        chk("byp_hit1", {63'd0, byp_hit1},  {63'd0, model_hit(byp_addr1)});
        chk("byp_hit2", {63'd0, byp_hit2},  {63'd0, model_hit(byp_addr2)});
        chk("byp_data1", {32'd0, byp_data1}, model_hit(byp_addr1) ? {32'd0, m_data} : 64'd0);
        chk("byp_data2", {32'd0, byp_data2}, model_hit(byp_addr2) ? {32'd0, m_data} : 64'd0);
    endtask

    task automatic tick();
        int w;
        @(posedge clk);
        w = model_winner();
        if (reset) begin
            m_wr = 1'b0; m_addr = '0; m_data = '0; m_gid = 0; m_last = 2;
        end else if (w >= 0) begin
            m_wr = (ta[w] != 0); m_addr = ta[w]; m_data = td[w]; m_gid = w; m_last = w;
        end else begin
            m_wr = 1'b0;
        end
        #1;
    endtask

    initial begin
        logic [2:0] seq [6];
        logic [2:0] granted;
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
        seq[3] = 3'b001; seq[4] = 3'b010; seq[5] = 3'b100;

        reset = 1'b1; hold = 1'b0; req_valid = 3'b000;
        for (int i = 0; i < 3; i++) begin ta[i] = '0; td[i] = '0; end
        byp_addr1 = '0; byp_addr2 = '0;
        m_last = 2; m_wr = 0; m_addr = '0; m_data = '0; m_gid = 0;
        tick(); tick();
        reset = 1'b0;
        settle();
        chk("reset_rf_wr", {63'd0, rf_wr}, 64'd0);
        tick();

        // Single write from requester 0.
        req_valid = 3'b001; ta[0] = 5; td[0] = 32'h1234;
        settle(); chk("t1_ready", {61'd0, req_ready}, 64'h1); tick();
        req_valid = 3'b000;
        settle();
        chk("t1_wr", {63'd0, rf_wr}, 64'd1);
        chk("t1_addr", {59'd0, rf_addr}, 64'd5);
        chk("t1_data", {32'd0, rf_data}, 64'h1234);
        chk("t1_gid", {62'd0, grant_id}, 64'd0);
        tick();
        settle(); chk("t1_drain", {63'd0, rf_wr}, 64'd0); tick();

        // All three valid from a fresh pointer: strict rotation.
        reset = 1'b1; tick(); reset = 1'b0;
        ta[0] = 3; ta[1] = 4; ta[2] = 6;
        td[0] = 32'hA0; td[1] = 32'hA1; td[2] = 32'hA2;
        req_valid = 3'b111;
        for (int j = 0; j < 7; j++) begin
            if (j == 6) req_valid = 3'b000;
            settle();
            if (j < 6) chk("rr_ready", {61'd0, req_ready}, {61'd0, seq[j]});
            if (j > 0) begin
                chk("rr_wr", {63'd0, rf_wr}, 64'd1);
                chk("rr_gid", {62'd0, grant_id}, 64'((j - 1) % 3));
            end
            tick();
        end

        // Write to $0 from requester 1: accepted, never committed.
        req_valid = 3'b010; ta[1] = 0; td[1] = 32'hFFFF;
        settle(); chk("z_ready", {61'd0, req_ready}, 64'h2); tick();
        req_valid = 3'b111; ta[1] = 4; byp_addr1 = 0;
        settle();
        chk("z_wr", {63'd0, rf_wr}, 64'd0);
        chk("z_hit1", {63'd0, byp_hit1}, 64'd0);
        chk("z_addr", {59'd0, rf_addr}, 64'd0);
        chk("z_data", {32'd0, rf_data}, 64'hFFFF);
        chk("z_next", {61'd0, req_ready}, 64'h4);
        tick();
        req_valid = 3'b000; settle(); tick();

        // Bypass of an in-flight write.
        req_valid = 3'b001; ta[0] = 7; td[0] = 32'hAB;
        settle(); tick();
        req_valid = 3'b000; byp_addr1 = 7; byp_addr2 = 8;
        settle();
        chk("b_hit1", {63'd0, byp_hit1}, 64'd1);
        chk("b_data1", {32'd0, byp_data1}, 64'hAB);
        chk("b_hit2", {63'd0, byp_hit2}, 64'd0);
        chk("b_data2", {32'd0, byp_data2}, 64'd0);
        tick();

        // Hold: pending write still issues, no grants, pointer preserved.
        req_valid = 3'b001; ta[0] = 9; td[0] = 32'h99;
        settle(); tick();
        hold = 1'b1; req_valid = 3'b110; ta[1] = 10; ta[2] = 11;
        for (int j = 0; j < 3; j++) begin
            settle();
            chk("h_ready", {61'd0, req_ready}, 64'd0);
            chk("h_wr", {63'd0, rf_wr}, (j == 0) ? 64'd1 : 64'd0);
            tick();
        end
        hold = 1'b0;
        settle(); chk("h_after", {61'd0, req_ready}, 64'h2); tick();

        // Reset while requester 2 is requesting: nothing is written.
        req_valid = 3'b100; reset = 1'b1;
        settle(); chk("r_ready", {61'd0, req_ready}, 64'd0); tick();
        reset = 1'b0; req_valid = 3'b111;
        settle();
        chk("r_wr", {63'd0, rf_wr}, 64'd0);
        chk("r_first", {61'd0, req_ready}, 64'h1);
        tick();

        // Random traffic; a requester only changes its request once granted or idle.
        req_valid = 3'b000;
        for (int n = 0; n < 400; n++) begin
            hold  = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 49) == 0);
            byp_addr1 = AW'($urandom_range(0, 7));
            byp_addr2 = AW'($urandom_range(0, 7));
            settle();
            granted = model_ready();
            tick();
            for (int i = 0; i < 3; i++) begin
                if (!req_valid[i] || granted[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    ta[i] = AW'($urandom_range(0, 7));
                    td[i] = $urandom;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
